// File: rtl/seg_scan_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// seg_scan_decoder: recovers 4 digit values from a multiplexed 7-seg scan bus
// Revision: 1.0
// ---------------------------------------------------------------------------
module seg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter bit          HEX_MODE      = 1'b0
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic [7:0]  seg_in,
  input  logic [3:0]  dig_sel,
  output logic [15:0] value,
  output logic [3:0]  digit_err,
  output logic        frame_valid,
  output logic        sync_err
);

  localparam logic [7:0] C_STABLE = STABLE_CYCLES[7:0];

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    ACQ     = 2'd1,
    PUBLISH = 2'd2
  } state_t;

  // dp never influences compare or decode, so it is not synchronized
  logic dp_unused;
  assign dp_unused = seg_in[7];

  logic [6:0]  seg_meta_q, seg_meta_d, seg_sync_q, seg_sync_d;
  logic [3:0]  sel_meta_q, sel_meta_d, sel_sync_q, sel_sync_d;
  logic [3:0]  sel_prev_q, sel_prev_d;
  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        locked_q, locked_d;
  logic [6:0]  last_q, last_d;
  logic [15:0] shadow_q, shadow_d;
  logic [3:0]  err_q, err_d;
  logic [15:0] value_q, value_d;
  logic [3:0]  digit_err_q, digit_err_d;
  logic        frame_valid_q, frame_valid_d;
  logic        sync_err_q, sync_err_d;

  logic [6:0]  s_seg;
  logic [3:0]  s_sel;
  logic [3:0]  onehot_cur, onehot_nxt;
  logic [7:0]  cnt_inc, cnt_n;
  logic [4:0]  dec;

  function automatic logic [4:0] decode(input logic [6:0] p);
    // result is {illegal, value}
    logic [4:0] r;
    r = 5'h10;
    case (p)
      7'h3F: r = 5'h00;
      7'h06: r = 5'h01;
      7'h5B: r = 5'h02;
      7'h4F: r = 5'h03;
      7'h66: r = 5'h04;
      7'h6D: r = 5'h05;
      7'h7D: r = 5'h06;
      7'h07: r = 5'h07;
      7'h7F: r = 5'h08;
      7'h6F: r = 5'h09;
      7'h77: r = HEX_MODE ? 5'h0A : 5'h10;
      7'h7C: r = HEX_MODE ? 5'h0B : 5'h10;
      7'h39: r = HEX_MODE ? 5'h0C : 5'h10;
      7'h5E: r = HEX_MODE ? 5'h0D : 5'h10;
      7'h79: r = HEX_MODE ? 5'h0E : 5'h10;
      7'h71: r = HEX_MODE ? 5'h0F : 5'h10;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  assign s_seg      = seg_sync_q;
  assign s_sel      = sel_sync_q;
  assign onehot_cur = 4'b0001 << idx_q;
  assign onehot_nxt = 4'b0010 << idx_q;
  assign cnt_inc    = (cnt_q < C_STABLE) ? cnt_q + 8'd1 : cnt_q;
  assign cnt_n      = (s_seg == last_q) ? cnt_inc : 8'd1;
  assign dec        = decode(s_seg);

  always_comb begin
    seg_meta_d    = seg_in[6:0];
    seg_sync_d    = seg_meta_q;
    sel_meta_d    = dig_sel;
    sel_sync_d    = sel_meta_q;
    sel_prev_d    = sel_sync_q;
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    locked_d      = locked_q;
    last_d        = last_q;
    shadow_d      = shadow_q;
    err_d         = err_q;
    value_d       = value_q;
    digit_err_d   = digit_err_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;

    case (state_q)
      SYNC: begin
        // start only on a fresh arrival at digit 0, so a 0001 seen during
        // PUBLISH or an abort does not restart mid-visit
        if (s_sel == 4'b0001 && sel_prev_q != 4'b0001) begin
          state_d  = ACQ;
          idx_d    = 2'd0;
          cnt_d    = 8'd1;
          locked_d = 1'b0;
          last_d   = s_seg;
          shadow_d = '0;
          err_d    = '0;
        end
      end
      ACQ: begin
        if (s_sel == onehot_cur) begin
          cnt_d  = cnt_n;
          last_d = s_seg;
          if (cnt_n == C_STABLE && !locked_q) begin
            shadow_d[{idx_q, 2'b00} +: 4] = dec[3:0];
            err_d[idx_q]                  = dec[4];
            locked_d                      = 1'b1;
          end
        end else if (s_sel == 4'b0000) begin
          state_d = ACQ;
        end else if (idx_q != 2'd3 && s_sel == onehot_nxt && locked_q) begin
          idx_d    = idx_q + 2'd1;
          cnt_d    = 8'd1;
          locked_d = 1'b0;
          last_d   = s_seg;
        end else if (idx_q == 2'd3 && locked_q) begin
          state_d       = PUBLISH;
          value_d       = shadow_q;
          digit_err_d   = err_q;
          frame_valid_d = 1'b1;
        end else begin
          state_d    = SYNC;
          sync_err_d = 1'b1;
          locked_d   = 1'b0;
          shadow_d   = '0;
          err_d      = '0;
        end
      end
      PUBLISH: begin
        state_d = SYNC;
      end
      default: begin
        state_d = SYNC;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      seg_meta_q    <= '0;
      seg_sync_q    <= '0;
      sel_meta_q    <= '0;
      sel_sync_q    <= '0;
      sel_prev_q    <= '0;
      state_q       <= SYNC;
      idx_q         <= '0;
      cnt_q         <= '0;
      locked_q      <= 1'b0;
      last_q        <= '0;
      shadow_q      <= '0;
      err_q         <= '0;
      value_q       <= '0;
      digit_err_q   <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      seg_meta_q    <= seg_meta_d;
      seg_sync_q    <= seg_sync_d;
      sel_meta_q    <= sel_meta_d;
      sel_sync_q    <= sel_sync_d;
      sel_prev_q    <= sel_prev_d;
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      locked_q      <= locked_d;
      last_q        <= last_d;
      shadow_q      <= shadow_d;
      err_q         <= err_d;
      value_q       <= value_d;
      digit_err_q   <= digit_err_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign value       = value_q;
  assign digit_err   = digit_err_q;
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// Scoreboard bench for seg_scan_decoder; a decimal and a hex instance share stimulus.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  seg_in = '0;
  logic [3:0]  dig_sel = '0;
  logic [15:0] value0, value1;
  logic [3:0]  derr0, derr1;
  logic        fv0, fv1, se0, se1;

  always #10 clk = ~clk;

  seg_scan_decoder #(.STABLE_CYCLES(4), .HEX_MODE(1'b0)) dut0 (
    .CLOCK_50(clk), .resetn(resetn), .seg_in(seg_in), .dig_sel(dig_sel),
    .value(value0), .digit_err(derr0), .frame_valid(fv0), .sync_err(se0));

  seg_scan_decoder #(.STABLE_CYCLES(4), .HEX_MODE(1'b1)) dut1 (
    .CLOCK_50(clk), .resetn(resetn), .seg_in(seg_in), .dig_sel(dig_sel),
    .value(value1), .digit_err(derr1), .frame_valid(fv1), .sync_err(se1));

  typedef struct packed {
    logic        is_frame;
    logic [15:0] value;
    logic [3:0]  err;
  } evt_t;

  evt_t        q0[$];
  evt_t        q1[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] pub0 = '0, pub1 = '0;
  logic [3:0]  perr0 = '0, perr1 = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mon(input int d, input logic fv, input logic se,
                     input logic [15:0] v, input logic [3:0] e);
    evt_t x;
    int   n;
    if (fv || se) begin
      chk($sformatf("dut%0d_pulse_exclusive", d), 32'(fv && se), 32'd0);
      n = (d == 0) ? q0.size() : q1.size();
      if (n == 0) begin
        checks++;
        errors++;
        $display("FAIL dut%0d_unexpected_pulse: got fv=%0b se=%0b expected none", d, fv, se);
      end else begin
        if (d == 0) x = q0.pop_front();
        else        x = q1.pop_front();
        chk($sformatf("dut%0d_kind", d), 32'(fv), 32'(x.is_frame));
        chk($sformatf("dut%0d_value", d), 32'(v), 32'(x.value));
        chk($sformatf("dut%0d_digit_err", d), 32'(e), 32'(x.err));
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, fv0, se0, value0, derr0);
    mon(1, fv1, se1, value1, derr1);
  end

  task automatic exp_frame(input logic [15:0] v0, input logic [3:0] e0,
                           input logic [15:0] v1, input logic [3:0] e1);
    q0.push_back({1'b1, v0, e0});
    q1.push_back({1'b1, v1, e1});
    pub0 = v0; perr0 = e0;
    pub1 = v1; perr1 = e1;
  endtask

  task automatic exp_abort();
    q0.push_back({1'b0, pub0, perr0});
    q1.push_back({1'b0, pub1, perr1});
  endtask

  task automatic drive(input logic [3:0] s, input logic [7:0] g, input int n);
    repeat (n) begin
      @(negedge clk);
      dig_sel = s;
      seg_in  = g;
    end
  endtask

  task automatic digit(input int i, input logic [7:0] g);
    drive(4'(1 << i), g, 8);
    drive(4'b0000, 8'h00, 2);
  endtask

  // leaving digit 3 towards 0010 publishes without re-arming digit 0
  task automatic frame(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d);
    digit(0, a); digit(1, b); digit(2, c); digit(3, d);
    drive(4'b0010, 8'h00, 2);
    drive(4'b0000, 8'h00, 4);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_value0"}, 32'(value0), 32'd0);
    chk({tag, "_value1"}, 32'(value1), 32'd0);
    chk({tag, "_derr0"},  32'(derr0),  32'd0);
    chk({tag, "_derr1"},  32'(derr1),  32'd0);
    chk({tag, "_pulses"}, 32'({fv0, se0, fv1, se1}), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wait_cyc;
    repeat (3) begin
      @(negedge clk);
      resetn  = 1'b0;
      seg_in  = 8'($urandom);
      dig_sel = 4'($urandom);
    end
    @(negedge clk);
    check_outputs_zero("reset");
    resetn  = 1'b1;
    seg_in  = '0;
    dig_sel = '0;
    drive(4'b0000, 8'h00, 6);
    check_outputs_zero("post_reset");

    exp_frame(16'h3210, 4'b0000, 16'h3210, 4'b0000);
    frame(8'h3F, 8'h06, 8'h5B, 8'h4F);

    exp_frame(16'h0010, 4'b0100, 16'h0A10, 4'b0000);
    frame(8'h3F, 8'h06, 8'h77, 8'h3F);

    exp_frame(16'h0000, 4'b1111, 16'hFDCB, 4'b0000);
    frame(8'h7C, 8'h39, 8'h5E, 8'h71);

    // digit 1: dp ignored, glitch restarts count, later change ignored once locked
    exp_frame(16'h4320, 4'b0000, 16'h4320, 4'b0000);
    digit(0, 8'h3F);
    drive(4'b0010, 8'h06, 1);
    drive(4'b0010, 8'h86, 1);
    drive(4'b0010, 8'h5B, 1);
    drive(4'b0010, 8'hDB, 3);
    drive(4'b0010, 8'h06, 2);
    drive(4'b0000, 8'h00, 2);
    digit(2, 8'h4F);
    digit(3, 8'h66);
    drive(4'b0010, 8'h00, 2);
    drive(4'b0000, 8'h00, 4);

    // digit 2 stable for only 3 cycles
    exp_abort();
    digit(0, 8'h3F);
    digit(1, 8'h06);
    drive(4'b0100, 8'h5B, 3);
    drive(4'b0000, 8'h00, 2);
    drive(4'b1000, 8'h4F, 8);
    drive(4'b0000, 8'h00, 6);

    exp_abort();
    drive(4'b0001, 8'h3F, 8);
    drive(4'b0100, 8'h5B, 4);
    drive(4'b0000, 8'h00, 4);

    exp_abort();
    drive(4'b0001, 8'h3F, 8);
    drive(4'b0000, 8'h00, 2);
    drive(4'b0011, 8'h3F, 4);
    drive(4'b0000, 8'h00, 4);

    exp_abort();
    drive(4'b0001, 8'h3F, 8);
    drive(4'b0000, 8'h00, 2);
    drive(4'b0010, 8'h06, 8);
    drive(4'b0000, 8'h00, 2);
    drive(4'b0001, 8'h3F, 4);
    drive(4'b0000, 8'h00, 4);

    exp_frame(16'h4321, 4'b0000, 16'h4321, 4'b0000);
    frame(8'h06, 8'h5B, 8'h4F, 8'h66);

    // reset while digit 2 is strobed
    digit(0, 8'h3F);
    digit(1, 8'h06);
    drive(4'b0100, 8'h5B, 4);
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("mid_reset");
    pub0 = '0; perr0 = '0; pub1 = '0; perr1 = '0;
    resetn  = 1'b1;
    dig_sel = '0;
    seg_in  = '0;
    drive(4'b0000, 8'h00, 4);

    exp_frame(16'h9876, 4'b0000, 16'h9876, 4'b0000);
    frame(8'h7D, 8'h07, 8'h7F, 8'h6F);

    wait_cyc = 0;
    while ((q0.size() != 0 || q1.size() != 0) && wait_cyc < 100) begin
      @(negedge clk);
      wait_cyc++;
    end
    chk("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
